// File: rtl/doorlock_ctrl.sv
// doorlock_ctrl: keypad PIN sequencer with relock timer, entry timeout and failure lockout; DOORLOCK_PROG_EN enables PIN reprogramming while OPEN.
// All outputs registered; ENTER at edge t yields the verdict at edge t+1; no backpressure, one key pulse may arrive every cycle.
module doorlock_ctrl #(
  parameter int unsigned          PIN_LEN       = 4,
  parameter logic [3*PIN_LEN-1:0] DEFAULT_PIN   = 12'h8D1,
  parameter int unsigned          MAX_FAIL      = 3,
  parameter logic [23:0]          OPEN_CYCLES   = 24'd50000,
  parameter logic [23:0]          LOCK_CYCLES   = 24'd200000,
  parameter logic [23:0]          ENTRY_TIMEOUT = 24'd100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] key_edge,
  output logic       unlock,
  output logic       alarm,
  output logic       ok_pulse,
  output logic       err_pulse,
  output logic [3:0] digit_cnt,
  output logic [3:0] fail_cnt
);
  localparam int unsigned BW = 3 * PIN_LEN;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_LOCKOUT
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [BW-1:0] r_buf, w_buf_nxt, w_buf_wr, w_pin;
  logic [3:0]    r_cnt, w_cnt_nxt;
  logic [3:0]    r_fail, w_fail_nxt;
  logic [23:0]   r_tmr, w_tmr_nxt, w_tmr_dec;
  logic          r_unlock, w_unlock_nxt;
  logic          r_alarm, w_alarm_nxt;
  logic          r_ok, w_ok_nxt;
  logic          r_err, w_err_nxt;
  logic          w_valid, w_digit_key, w_clr, w_ent;
  logic          w_full, w_match, w_expire, w_fail_last;
  logic [2:0]    w_digit;

`ifdef DOORLOCK_PROG_EN
  logic [BW-1:0] r_pin, w_pin_nxt;
  assign w_pin = r_pin;
`else
  assign w_pin = DEFAULT_PIN;
`endif

  always_comb begin
    w_valid     = (key_edge != 8'd0) && ((key_edge & (key_edge - 8'd1)) == 8'd0);
    w_digit_key = w_valid && (key_edge[7:6] == 2'b00);
    w_clr       = w_valid && key_edge[6];
    w_ent       = w_valid && key_edge[7];
    w_digit     = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (key_edge[i]) w_digit = 3'(i);
    end
    w_buf_wr = r_buf;
    for (int k = 0; k < PIN_LEN; k++) begin
      if (r_cnt == 4'(k)) w_buf_wr[3*k +: 3] = w_digit;
    end
    w_full      = (r_cnt == 4'(PIN_LEN));
    w_match     = w_full && (r_buf == w_pin);
    w_tmr_dec   = (r_tmr == 24'd0) ? 24'd0 : r_tmr - 24'd1;
    // Expire on the edge where the count would reach zero, so a load of N gives N cycles.
    w_expire    = (r_tmr <= 24'd1);
    w_fail_last = ({1'b0, r_fail} + 5'd1) >= 5'(MAX_FAIL);
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_buf_nxt    = r_buf;
    w_cnt_nxt    = r_cnt;
    w_fail_nxt   = r_fail;
    w_tmr_nxt    = r_tmr;
    w_unlock_nxt = r_unlock;
    w_alarm_nxt  = r_alarm;
    w_ok_nxt     = 1'b0;
    w_err_nxt    = 1'b0;
`ifdef DOORLOCK_PROG_EN
    w_pin_nxt    = r_pin;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_digit_key) begin
          w_buf_nxt      = '0;
          w_buf_nxt[2:0] = w_digit;
          w_cnt_nxt      = 4'd1;
          w_tmr_nxt      = ENTRY_TIMEOUT;
          w_state_nxt    = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (w_digit_key) begin
          if (!w_full) begin
            w_buf_nxt = w_buf_wr;
            w_cnt_nxt = r_cnt + 4'd1;
          end
          w_tmr_nxt = ENTRY_TIMEOUT;
        end else if (w_ent) begin
          w_state_nxt = S_CHECK;
        end else if (w_clr || w_expire) begin
          w_buf_nxt   = '0;
          w_cnt_nxt   = 4'd0;
          w_tmr_nxt   = 24'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_tmr_nxt = w_tmr_dec;
        end
      end
      S_CHECK: begin
        w_buf_nxt = '0;
        w_cnt_nxt = 4'd0;
        if (w_match) begin
          w_ok_nxt     = 1'b1;
          w_fail_nxt   = 4'd0;
          w_unlock_nxt = 1'b1;
          w_tmr_nxt    = OPEN_CYCLES;
          w_state_nxt  = S_OPEN;
        end else if (!w_fail_last) begin
          w_err_nxt   = 1'b1;
          w_fail_nxt  = r_fail + 4'd1;
          w_tmr_nxt   = 24'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_err_nxt   = 1'b1;
          w_fail_nxt  = 4'd0;
          w_alarm_nxt = 1'b1;
          w_tmr_nxt   = LOCK_CYCLES;
          w_state_nxt = S_LOCKOUT;
        end
      end
      S_OPEN: begin
        w_tmr_nxt = w_tmr_dec;
        if (w_clr || w_expire) begin
          w_unlock_nxt = 1'b0;
          w_buf_nxt    = '0;
          w_cnt_nxt    = 4'd0;
          w_tmr_nxt    = 24'd0;
          w_state_nxt  = S_IDLE;
        end
`ifdef DOORLOCK_PROG_EN
        else if (w_digit_key) begin
          if (!w_full) begin
            w_buf_nxt = w_buf_wr;
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end else if (w_ent) begin
          w_buf_nxt = '0;
          w_cnt_nxt = 4'd0;
          if (w_full) begin
            w_pin_nxt    = r_buf;
            w_ok_nxt     = 1'b1;
            w_unlock_nxt = 1'b0;
            w_tmr_nxt    = 24'd0;
            w_state_nxt  = S_IDLE;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
`endif
      end
      S_LOCKOUT: begin
        w_tmr_nxt = w_tmr_dec;
        if (w_expire) begin
          w_alarm_nxt = 1'b0;
          w_tmr_nxt   = 24'd0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_buf    <= '0;
      r_cnt    <= 4'd0;
      r_fail   <= 4'd0;
      r_tmr    <= 24'd0;
      r_unlock <= 1'b0;
      r_alarm  <= 1'b0;
      r_ok     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_buf    <= w_buf_nxt;
      r_cnt    <= w_cnt_nxt;
      r_fail   <= w_fail_nxt;
      r_tmr    <= w_tmr_nxt;
      r_unlock <= w_unlock_nxt;
      r_alarm  <= w_alarm_nxt;
      r_ok     <= w_ok_nxt;
      r_err    <= w_err_nxt;
    end
  end

`ifdef DOORLOCK_PROG_EN
  always_ff @(posedge clk) begin
    if (rst) r_pin <= DEFAULT_PIN;
    else     r_pin <= w_pin_nxt;
  end
`endif

  assign unlock    = r_unlock;
  assign alarm     = r_alarm;
  assign ok_pulse  = r_ok;
  assign err_pulse = r_err;
  assign digit_cnt = r_cnt;
  assign fail_cnt  = r_fail;

endmodule

// File: tb/tb_doorlock_ctrl.sv
// Bench for doorlock_ctrl: vector table, timed corner sequences, and random traffic against a deadline-based reference model.
module tb_doorlock_ctrl;
  localparam int PIN_LEN  = 4;
  localparam int MAX_FAIL = 3;
  localparam int OPEN_N   = 8;
  localparam int LOCK_N   = 16;
  localparam int ENTRY_N  = 20;
  localparam logic [7:0] CLR = 8'h40;
  localparam logic [7:0] ENT = 8'h80;
  localparam int M_IDLE = 0, M_ENTRY = 1, M_CHECK = 2, M_OPEN = 3, M_LOCK = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_edge;
  logic       unlock, alarm, ok_pulse, err_pulse;
  logic [3:0] digit_cnt, fail_cnt;

  always #5 clk = ~clk;

  doorlock_ctrl #(
    .PIN_LEN(4), .DEFAULT_PIN(12'h8D1), .MAX_FAIL(3),
    .OPEN_CYCLES(24'd8), .LOCK_CYCLES(24'd16), .ENTRY_TIMEOUT(24'd20)
  ) dut (
    .clk(clk), .rst(rst), .key_edge(key_edge),
    .unlock(unlock), .alarm(alarm), .ok_pulse(ok_pulse), .err_pulse(err_pulse),
    .digit_cnt(digit_cnt), .fail_cnt(fail_cnt)
  );

  int errors = 0;
  int checks = 0;
  int tot_unl = 0, tot_alm = 0, tot_ok = 0, tot_err = 0;

  // Reference model: mode plus edge-number deadlines and a digit queue.
  int m_ph = M_IDLE, m_fail = 0, m_mark = 0, m_n = 0;
  int m_q[$];
  int m_pin[PIN_LEN] = '{1, 2, 3, 4};
  bit m_ok = 0, m_err = 0;

  task automatic model_step(input logic [7:0] k, input bit r);
    bit valid, dig, clr, ent, good;
    int d;
    m_n++;
    m_ok  = 0;
    m_err = 0;
    valid = ($countones(k) == 1);
    dig   = valid && (k < 8'h40);
    clr   = valid && (k == CLR);
    ent   = valid && (k == ENT);
    d     = 0;
    for (int i = 0; i < 6; i++) if (k[i]) d = i;
    if (r) begin
      m_ph = M_IDLE;
      m_q.delete();
      m_fail = 0;
      m_pin = '{1, 2, 3, 4};
    end else begin
      case (m_ph)
        M_IDLE: if (dig) begin
          m_q.delete(); m_q.push_back(d); m_mark = m_n; m_ph = M_ENTRY;
        end
        M_ENTRY: if (dig) begin
          if (m_q.size() < PIN_LEN) m_q.push_back(d);
          m_mark = m_n;
        end else if (clr) begin
          m_q.delete(); m_ph = M_IDLE;
        end else if (ent) begin
          m_ph = M_CHECK;
        end else if (m_n - m_mark >= ENTRY_N) begin
          m_q.delete(); m_ph = M_IDLE;
        end
        M_CHECK: begin
          good = (m_q.size() == PIN_LEN);
          if (good) for (int i = 0; i < PIN_LEN; i++) if (m_q[i] != m_pin[i]) good = 0;
          m_q.delete();
          if (good) begin
            m_ok = 1; m_fail = 0; m_ph = M_OPEN; m_mark = m_n;
          end else begin
            m_err = 1;
            if (m_fail + 1 >= MAX_FAIL) begin
              m_fail = 0; m_ph = M_LOCK; m_mark = m_n;
            end else begin
              m_fail++; m_ph = M_IDLE;
            end
          end
        end
        M_OPEN: if (clr || (m_n - m_mark >= OPEN_N)) begin
          m_q.delete(); m_ph = M_IDLE;
        end
`ifdef DOORLOCK_PROG_EN
        else if (dig) begin
          if (m_q.size() < PIN_LEN) m_q.push_back(d);
        end else if (ent) begin
          if (m_q.size() == PIN_LEN) begin
            for (int i = 0; i < PIN_LEN; i++) m_pin[i] = m_q[i];
            m_ok = 1; m_ph = M_IDLE;
          end else begin
            m_err = 1;
          end
          m_q.delete();
        end
`endif
        M_LOCK: if (m_n - m_mark >= LOCK_N) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
    end
  endtask

  task automatic cycle(input logic [7:0] k, input bit r);
    logic [11:0] exp_v, act_v;
    @(negedge clk);
    key_edge = k;
    rst      = r;
    @(posedge clk);
    model_step(k, r);
    #1;
    act_v = {unlock, alarm, ok_pulse, err_pulse, digit_cnt, fail_cnt};
    exp_v = {m_ph == M_OPEN, m_ph == M_LOCK, m_ok, m_err, 4'(m_q.size()), 4'(m_fail)};
    tot_unl += int'(unlock);
    tot_alm += int'(alarm);
    tot_ok  += int'(ok_pulse);
    tot_err += int'(err_pulse);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model_cycle%0d key=%h rst=%0d: u/a/ok/err/cnt/fail got %h required %h",
               m_n, k, r, act_v, exp_v);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, want);
    end
  endtask

  task automatic press(input int d);
    cycle(8'(1 << d), 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(8'h00, 1'b0);
  endtask

  task automatic code4(input int a, input int b, input int c, input int d);
    press(a); press(b); press(c); press(d);
    cycle(ENT, 1'b0);
    cycle(8'h00, 1'b0);
  endtask

  typedef struct {
    logic [7:0]  key;
    bit          rst;
    logic [11:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [11:0] mk(bit u, bit a, bit o, bit e, int c, int f);
    return {u, a, o, e, 4'(c), 4'(f)};
  endfunction

  task automatic add(input logic [7:0] k, input bit r, input logic [11:0] e);
    vec_t v;
    v.key = k; v.rst = r; v.exp = e;
    vecs.push_back(v);
  endtask

  initial begin
    int b_ok, b_err, b_unl, b_alm, r, p;
    logic [11:0] act;
    rst = 1'b1;
    key_edge = 8'h00;

    // {key, rst} -> {unlock, alarm, ok, err, digit_cnt, fail_cnt}
    add(8'h00, 1, mk(0, 0, 0, 0, 0, 0));
    add(8'h02, 1, mk(0, 0, 0, 0, 0, 0));
    add(8'h02, 0, mk(0, 0, 0, 0, 1, 0));
    add(8'h04, 0, mk(0, 0, 0, 0, 2, 0));
    add(8'h03, 0, mk(0, 0, 0, 0, 2, 0));
    add(8'h08, 0, mk(0, 0, 0, 0, 3, 0));
    add(8'h10, 0, mk(0, 0, 0, 0, 4, 0));
    add(8'h20, 0, mk(0, 0, 0, 0, 4, 0));
    add(ENT,   0, mk(0, 0, 0, 0, 4, 0));
    add(8'h00, 0, mk(1, 0, 1, 0, 0, 0));
    add(8'h00, 0, mk(1, 0, 0, 0, 0, 0));
    add(CLR,   0, mk(0, 0, 0, 0, 0, 0));
    add(8'h02, 0, mk(0, 0, 0, 0, 1, 0));
    add(8'h04, 0, mk(0, 0, 0, 0, 2, 0));
    add(8'h08, 0, mk(0, 0, 0, 0, 3, 0));
    add(ENT,   0, mk(0, 0, 0, 0, 3, 0));
    add(8'h00, 0, mk(0, 0, 0, 1, 0, 1));
    add(8'h00, 0, mk(0, 0, 0, 0, 0, 1));
    add(ENT,   0, mk(0, 0, 0, 0, 0, 1));
    add(CLR,   0, mk(0, 0, 0, 0, 0, 1));
    add(8'h01, 0, mk(0, 0, 0, 0, 1, 1));
    add(CLR,   0, mk(0, 0, 0, 0, 0, 1));
    add(8'h02, 0, mk(0, 0, 0, 0, 1, 1));
    add(ENT,   0, mk(0, 0, 0, 0, 1, 1));
    add(8'h00, 0, mk(0, 0, 0, 1, 0, 2));
    add(8'h02, 0, mk(0, 0, 0, 0, 1, 2));
    add(ENT,   0, mk(0, 0, 0, 0, 1, 2));
    add(8'h00, 0, mk(0, 1, 0, 1, 0, 0));
    add(8'h02, 0, mk(0, 1, 0, 0, 0, 0));
    add(CLR,   0, mk(0, 1, 0, 0, 0, 0));
    add(8'h00, 1, mk(0, 0, 0, 0, 0, 0));
    add(8'h02, 0, mk(0, 0, 0, 0, 1, 0));

    foreach (vecs[i]) begin
      cycle(vecs[i].key, vecs[i].rst);
      act = {unlock, alarm, ok_pulse, err_pulse, digit_cnt, fail_cnt};
      checks++;
      if (act !== vecs[i].exp) begin
        errors++;
        $display("FAIL vec%0d: got %h required %h", i, act, vecs[i].exp);
      end
    end

    // Correct code: one ok pulse, unlock for exactly OPEN_N cycles.
    cycle(8'h00, 1);
    b_ok = tot_ok; b_unl = tot_unl;
    code4(1, 2, 3, 4);
    idle(12);
    chk("open_ok_pulses", tot_ok - b_ok, 1);
    chk("open_unlock_cycles", tot_unl - b_unl, OPEN_N);
    chk("open_fail_cnt", int'(fail_cnt), 0);
    chk("open_relocked", int'(unlock), 0);

    // Three wrong codes -> lockout for LOCK_N cycles, keys ignored meanwhile.
    cycle(8'h00, 1);
    b_err = tot_err; b_alm = tot_alm;
    code4(1, 2, 3, 5);
    chk("fail_after_1", int'(fail_cnt), 1);
    code4(1, 2, 3, 5);
    chk("fail_after_2", int'(fail_cnt), 2);
    code4(1, 2, 3, 5);
    chk("lockout_alarm_on", int'(alarm), 1);
    chk("lockout_fail_cnt", int'(fail_cnt), 0);
    b_ok = tot_ok;
    code4(1, 2, 3, 4);
    idle(20);
    chk("lockout_err_pulses", tot_err - b_err, 3);
    chk("lockout_alarm_cycles", tot_alm - b_alm, LOCK_N);
    chk("lockout_keys_ignored", tot_ok - b_ok, 0);
    chk("lockout_no_unlock", int'(unlock), 0);

    // Entry timeout, short code, extra digit, CLEAR relock.
    cycle(8'h00, 1);
    b_err = tot_err;
    press(1); press(2);
    idle(ENTRY_N - 1);
    chk("timeout_not_yet", int'(digit_cnt), 2);
    idle(1);
    chk("timeout_cleared", int'(digit_cnt), 0);
    chk("timeout_no_err", tot_err - b_err, 0);
    press(1); press(2); press(3);
    cycle(ENT, 0); cycle(8'h00, 0);
    chk("short_code_err", tot_err - b_err, 1);
    b_ok = tot_ok;
    press(1); press(2); press(3); press(4); press(5);
    cycle(ENT, 0); cycle(8'h00, 0);
    chk("extra_digit_ok", tot_ok - b_ok, 1);
    chk("extra_digit_unlock", int'(unlock), 1);
    cycle(CLR, 0);
    chk("clear_relock", int'(unlock), 0);

    // Zero and multi-hot keys neither count as digits nor reload the timer.
    cycle(8'h00, 1);
    press(1);
    for (int i = 0; i < ENTRY_N - 1; i++) cycle((i % 2 == 0) ? 8'h03 : 8'h00, 0);
    chk("multihot_cnt_kept", int'(digit_cnt), 1);
    cycle(8'h03, 0);
    chk("multihot_timeout", int'(digit_cnt), 0);

    // Reset mid-OPEN, mid-LOCKOUT and with failures pending.
    cycle(8'h00, 1);
    code4(1, 2, 3, 4);
    idle(2);
    cycle(8'h00, 1);
    chk("rst_open_unlock", int'(unlock), 0);
    code4(1, 2, 3, 5); code4(1, 2, 3, 5); code4(1, 2, 3, 5);
    idle(3);
    cycle(8'h00, 1);
    chk("rst_lock_alarm", int'(alarm), 0);
    code4(0, 0, 0, 0);
    chk("pre_rst_fail", int'(fail_cnt), 1);
    cycle(8'h00, 1);
    chk("rst_fail_clear", int'(fail_cnt), 0);
    press(3);
    chk("rst_then_idle", int'(digit_cnt), 1);

`ifdef DOORLOCK_PROG_EN
    cycle(8'h00, 1);
    code4(1, 2, 3, 4);
    b_ok = tot_ok;
    code4(5, 5, 0, 1);
    chk("prog_ok", tot_ok - b_ok, 1);
    chk("prog_relock", int'(unlock), 0);
    b_err = tot_err;
    code4(1, 2, 3, 4);
    chk("prog_old_rejected", tot_err - b_err, 1);
    code4(5, 5, 0, 1);
    chk("prog_new_unlocks", int'(unlock), 1);
    b_err = tot_err;
    press(5);
    cycle(ENT, 0);
    chk("prog_short_err", tot_err - b_err, 1);
    chk("prog_short_stays_open", int'(unlock), 1);
    cycle(8'h00, 1);
    code4(1, 2, 3, 4);
    chk("prog_rst_default", int'(unlock), 1);
`else
    cycle(8'h00, 1);
    code4(1, 2, 3, 4);
    b_ok = tot_ok;
    press(5); press(5); press(0); press(1);
    cycle(ENT, 0);
    chk("open_digits_ignored", int'(digit_cnt), 0);
    chk("open_enter_ignored", tot_ok - b_ok, 0);
    chk("open_still_unlocked", int'(unlock), 1);
`endif

    // Random traffic: digits mostly follow 1,2,3,4 so correct codes occur.
    cycle(8'h00, 1);
    p = 1;
    for (int it = 0; it < 4000; it++) begin
      r = $urandom_range(0, 99);
      if (r < 45) cycle(8'h00, 0);
      else if (r < 68) begin
        cycle(8'(1 << p), 0);
        p = (p == 4) ? 1 : p + 1;
      end
      else if (r < 76) cycle(8'(1 << $urandom_range(0, 5)), 0);
      else if (r < 84) begin cycle(ENT, 0); p = 1; end
      else if (r < 88) begin cycle(CLR, 0); p = 1; end
      else if (r < 95) cycle(8'($urandom_range(0, 255)), 0);
      else if (r < 98) idle(22);
      else if (r < 99) begin cycle(8'h00, 1); p = 1; end
      else p = 1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
